// File: rtl/cla_result_stage.sv
// ============================================================================
// Module   : cla_result_stage
// Purpose  : Result buffer behind cla_64bit. Derives zero/neg/ovf flags and
//            presents results through a valid/ready FIFO.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cla_result_stage #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_sum,
  input  logic                       in_cout,
  input  logic                       in_a_msb,
  input  logic                       in_b_msb,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_sum,
  output logic                       out_cout,
  output logic                       out_zero,
  output logic                       out_neg,
  output logic                       out_ovf,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int                 c_ptr_w = $clog2(DEPTH);
  localparam int                 c_cnt_w = c_ptr_w + 1;
  localparam int                 c_ent_w = WIDTH + 4;
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);

  logic [c_ent_w-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic               w_push;
  logic               w_pop;
  logic               w_zero;
  logic               w_neg;
  logic               w_ovf;
  logic [c_ent_w-1:0] w_entry;

  // Flags depend only on the pushed inputs, so they are frozen with the entry.
  assign w_zero  = ~|in_sum;
  assign w_neg   = in_sum[WIDTH-1];
  assign w_ovf   = (in_a_msb == in_b_msb) && (in_sum[WIDTH-1] != in_a_msb);
  assign w_entry = {in_sum, in_cout, w_zero, w_neg, w_ovf};

  assign in_ready  = (r_count != c_full);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry is read straight from storage; stale while empty.
  assign {out_sum, out_cout, out_zero, out_neg, out_ovf} = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_cla_result_stage.sv
// ============================================================================
// Module   : tb_cla_result_stage
// Purpose  : Directed self-checking bench for cla_result_stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cla_result_stage;

  localparam int WIDTH = 64;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             zero;
    logic             neg;
    logic             ovf;
  } ent_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic             in_cout;
  logic             in_a_msb;
  logic             in_b_msb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_zero;
  logic             out_neg;
  logic             out_ovf;
  logic [1:0]       count;

  int checks = 0;
  int errors = 0;

  cla_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .in_a_msb  (in_a_msb),
    .in_b_msb  (in_b_msb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_ovf   (out_ovf),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] s, input logic c,
                       input logic am, input logic bm);
    in_valid = v;
    in_sum   = s;
    in_cout  = c;
    in_a_msb = am;
    in_b_msb = bm;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if ({out_sum, out_cout, out_zero, out_neg, out_ovf} !== '0) begin
      errors++; $display("FAIL reset_out_fields: got sum=%h c=%b z=%b n=%b o=%b expected all 0",
                         out_sum, out_cout, out_zero, out_neg, out_ovf);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    checks++; if (out_sum !== 64'h1) begin errors++; $display("FAIL single_sum: got %h expected 1", out_sum); end
    checks++; if ({out_cout, out_zero, out_neg, out_ovf} !== 4'b0000) begin
      errors++; $display("FAIL single_flags: got %b expected 0000", {out_cout, out_zero, out_neg, out_ovf});
    end
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", out_valid); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL single_drain_count: got %0d expected 0", count); end
  endtask

  task automatic test_flags();
    out_ready = 1'b1;
    drive(1'b1, 64'h0, 1'b1, 1'b0, 1'b0);
    step();
    checks++; if ({out_valid, out_cout, out_zero, out_neg, out_ovf} !== 5'b11100) begin
      errors++; $display("FAIL flags_zero: got v/c/z/n/o=%b expected 11100", {out_valid, out_cout, out_zero, out_neg, out_ovf});
    end
    drive(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if ({out_valid, out_cout, out_zero, out_neg, out_ovf} !== 5'b10011) begin
      errors++; $display("FAIL flags_pos_ovf: got v/c/z/n/o=%b expected 10011", {out_valid, out_cout, out_zero, out_neg, out_ovf});
    end
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL flags_count: got %0d expected 1", count); end
    drive(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    step();
    checks++; if ({out_valid, out_cout, out_zero, out_neg, out_ovf} !== 5'b10010) begin
      errors++; $display("FAIL flags_mixed_sign: got v/c/z/n/o=%b expected 10010", {out_valid, out_cout, out_zero, out_neg, out_ovf});
    end
    drive(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1);
    step();
    checks++; if ({out_valid, out_cout, out_zero, out_neg, out_ovf} !== 5'b11001) begin
      errors++; $display("FAIL flags_neg_ovf: got v/c/z/n/o=%b expected 11001", {out_valid, out_cout, out_zero, out_neg, out_ovf});
    end
    checks++; if (out_sum !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL flags_sum: got %h expected 7fffffffffffffff", out_sum); end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flags_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 64'hAAAA_0000_0000_0001, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if (count !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_first: got count=%0d ready=%b expected 1/1", count, in_ready); end
    drive(1'b1, 64'hBBBB_0000_0000_0002, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if (count !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got count=%0d ready=%b expected 2/0", count, in_ready); end
    checks++; if (out_sum !== 64'hAAAA_0000_0000_0001) begin errors++; $display("FAIL bp_head: got %h expected aaaa000000000001", out_sum); end
    drive(1'b1, 64'hCCCC_0000_0000_0003, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if (count !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_held: got count=%0d ready=%b expected 2/0", count, in_ready); end
    checks++; if (out_valid !== 1'b1 || out_sum !== 64'hAAAA_0000_0000_0001) begin
      errors++; $display("FAIL bp_stable: got v=%b sum=%h expected 1/aaaa000000000001", out_valid, out_sum);
    end
    out_ready = 1'b1;
    step();
    checks++; if (count !== 2'd1 || out_sum !== 64'hBBBB_0000_0000_0002) begin
      errors++; $display("FAIL bp_release1: got count=%0d sum=%h expected 1/bbbb000000000002", count, out_sum);
    end
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 2'd1 || out_sum !== 64'hCCCC_0000_0000_0003) begin
      errors++; $display("FAIL bp_release2: got count=%0d sum=%h expected 1/cccc000000000003", count, out_sum);
    end
    step();
    checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got count=%0d v=%b expected 0/0", count, out_valid); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 64'(100 + i), 1'b0, 1'b0, 1'b0);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 64'(100 + i) || count !== 2'd1) begin
        errors++; $display("FAIL stream_%0d: got v=%b sum=%0d count=%0d expected 1/%0d/1", i, out_valid, out_sum, count, 100 + i);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL stream_drain: got v=%b count=%0d expected 0/0", out_valid, count); end
  endtask

  task automatic test_wrap();
    ent_t q[$];
    ent_t e;
    logic push, pop;
    int   npush = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      e.sum  = {$urandom, $urandom};
      if (cyc % 7 == 3) e.sum = '0;
      e.cout = 1'($urandom_range(0, 1));
      in_a_msb = 1'($urandom_range(0, 1));
      in_b_msb = 1'($urandom_range(0, 1));
      e.zero = (e.sum == '0);
      e.neg  = e.sum[WIDTH-1];
      e.ovf  = (in_a_msb == in_b_msb) && (e.sum[WIDTH-1] != in_a_msb);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_sum    = e.sum;
      in_cout   = e.cout;
      push = in_valid && (q.size() < DEPTH);
      pop  = out_ready && (q.size() > 0);
      step();
      if (pop) void'(q.pop_front());
      if (push) begin q.push_back(e); npush++; end
      checks++;
      if (count !== 2'(q.size()) || out_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL wrap_occ_%0d: got count=%0d v=%b expected %0d/%b", cyc, count, out_valid, q.size(), q.size() != 0);
      end
      if (q.size() != 0) begin
        checks++;
        if ({out_sum, out_cout, out_zero, out_neg, out_ovf} !== q[0]) begin
          errors++; $display("FAIL wrap_head_%0d: got sum=%h cznv=%b expected sum=%h cznv=%b", cyc,
                             out_sum, {out_cout, out_zero, out_neg, out_ovf},
                             q[0].sum, {q[0].cout, q[0].zero, q[0].neg, q[0].ovf});
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0) begin
      step();
      void'(q.pop_front());
      if (q.size() != 0) begin
        checks++;
        if (out_sum !== q[0].sum) begin errors++; $display("FAIL wrap_tail: got %h expected %h", out_sum, q[0].sum); end
      end
    end
    checks++; if (npush < 9) begin errors++; $display("FAIL wrap_pushes: got %0d expected at least 9", npush); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive(1'b1, 64'h1111, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h2222, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL rst_mid_fill: got %0d expected 2", count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_async: got v=%b count=%0d ready=%b expected 0/0/1", out_valid, count, in_ready);
    end
    checks++; if (out_sum !== '0 || out_cout !== 1'b0) begin errors++; $display("FAIL rst_mid_sum: got %h/%b expected 0/0", out_sum, out_cout); end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0) begin
        errors++; $display("FAIL rst_mid_lost_%0d: got v=%b count=%0d expected 0/0", i, out_valid, count);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    test_reset();
    #11 rst_n = 1'b1;
    test_single();
    test_flags();
    test_backpressure();
    test_streaming();
    test_wrap();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
